// File: rtl/uart_wr_ctrl.sv
// uart_wr_ctrl: bus-facing write controller for a UART TX/RX core pair.
// Software writes a TX byte (data register) and sets "send" (control
// register); the FSM then pulses tx_start_o once and tracks the TX core busy
// flag until the byte has left, clearing "send" when done. Received bytes
// are latched and flagged through new_rx.
//
// Ports:
//   clk_i       in   1  clock, rising edge
//   rst_i       in   1  synchronous active-high reset
//   we_i        in   1  bus write strobe
//   reg_sel_i   in   1  0 = control register, 1 = data register
//   data_i      in  32  bus write data
//   rx_valid_i  in   1  RX core byte-valid pulse
//   rx_data_i   in   8  RX core byte
//   tx_busy_i   in   1  TX core busy flag
//   tx_start_o  out  1  one-cycle TX launch pulse
//   tx_data_o   out  8  held TX byte
//   outc_o      out 32  control view {29'b0, tx_err, new_rx, send}
//   outd_o      out 32  data view {24'b0, rx byte}
//
// Build option: define UART_TX_TIMEOUT_EN to abort a launch that never sees
// tx_busy_i within 16 cycles (sets tx_err). Without it tx_err reads 0.

module uart_wr_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic        reg_sel_i,
    input  logic [31:0] data_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    output logic [31:0] outc_o,
    output logic [31:0] outd_o
);

    localparam int unsigned DataW = 32;
    localparam int unsigned ByteW = 8;
    localparam int unsigned CtrlW = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic             send_q;
    logic             tx_start_q;
    logic             new_rx_q, new_rx_d;
    logic [ByteW-1:0] tx_byte_q, tx_byte_d;
    logic [ByteW-1:0] rx_byte_q, rx_byte_d;
    logic             tx_err;

    logic ctrl_wr;
    logic data_wr;
    logic in_idle;

    assign ctrl_wr = we_i & ~reg_sel_i;
    assign data_wr = we_i & reg_sel_i;
    assign in_idle = (state_q == IDLE);

`ifdef UART_TX_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = 16;
    localparam int unsigned CntW          = $clog2(TimeoutCycles);

    logic [CntW-1:0] cnt_q;
    logic            tx_err_q;

    assign tx_err = tx_err_q;

    logic unused_data_bits;
    assign unused_data_bits = ^data_i[DataW-1:ByteW];
`else
    assign tx_err = 1'b0;

    logic unused_data_bits;
    assign unused_data_bits = ^{data_i[DataW-1:ByteW], data_i[2]};
`endif

    // Byte registers and new_rx flag; an RX arrival beats a software clear.
    always_comb begin
        tx_byte_d = tx_byte_q;
        rx_byte_d = rx_byte_q;
        new_rx_d  = new_rx_q;
        if (data_wr && in_idle) begin
            tx_byte_d = data_i[ByteW-1:0];
        end
        if (ctrl_wr && !data_i[1]) begin
            new_rx_d = 1'b0;
        end
        if (rx_valid_i) begin
            rx_byte_d = rx_data_i;
            new_rx_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_byte_q <= '0;
            rx_byte_q <= '0;
            new_rx_q  <= 1'b0;
        end else begin
            tx_byte_q <= tx_byte_d;
            rx_byte_q <= rx_byte_d;
            new_rx_q  <= new_rx_d;
        end
    end

    // Transmit sequencer, the send bit it owns, and the launch pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            send_q     <= 1'b0;
            tx_start_q <= 1'b0;
`ifdef UART_TX_TIMEOUT_EN
            cnt_q      <= '0;
            tx_err_q   <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (send_q) begin
                        state_q    <= START;
                        tx_start_q <= 1'b1;
                    end
                end
                START: begin
                    // Busy is ignored here so WAIT_BUSY is always visited.
                    state_q <= WAIT_BUSY;
`ifdef UART_TX_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        state_q <= WAIT_DONE;
`ifdef UART_TX_TIMEOUT_EN
                    end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                        state_q  <= IDLE;
                        send_q   <= 1'b0;
                        tx_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        state_q <= IDLE;
                        send_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Software may only change send/tx_err while nothing is in flight.
            if (ctrl_wr && in_idle) begin
                send_q <= data_i[0];
`ifdef UART_TX_TIMEOUT_EN
                if (!data_i[2]) begin
                    tx_err_q <= 1'b0;
                end
`endif
            end
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_byte_q;
    assign outc_o     = {{(DataW - CtrlW){1'b0}}, tx_err, new_rx_q, send_q};
    assign outd_o     = {{(DataW - ByteW){1'b0}}, rx_byte_q};

endmodule
